pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits between the hazard unit, the data-memory port and the multi-cycle mult/div unit.
- It merges three sources into one coherent set of per-stage register enables and bubble (flush) controls:
  - hazard-unit stalls,
  - variable-latency data-memory handshakes,
  - multi-cycle mult/div occupancy.
- It also owns the memory-wait timeout and a stall-cycle performance counter.

---
 rtl/mips_ctrl_pkg.sv | 11 +
 rtl/md_occupancy_ctr.sv | 62 ++++++
 rtl/pipeline_stall_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared FSM state types and default latencies for the pipeline control slice
package mips_ctrl_pkg;

   typedef enum logic [1:0] {M_RUN, M_WAIT, M_ERR} mem_state_t;
   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 32;
   localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/md_occupancy_ctr.sv
// rtl/md_occupancy_ctr.sv - mult/div EX occupancy FSM: holds the op in EX for its fixed latency
module md_occupancy_ctr #(
   parameter int MULT_CYCLES = mips_ctrl_pkg::MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = mips_ctrl_pkg::DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_EX,
   input  logic md_is_div_EX,
   input  logic en_ex,
   output logic md_hold,
   output logic md_busy
);
   import mips_ctrl_pkg::*;

   localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW   = $clog2(MAXC);

   md_state_t       state;
   logic [CW-1:0]   cnt;

   // The IDLE cycle that first sees the op is occupancy cycle 1, so BUSY loads N-2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (md_start_EX) begin
                  state   <= MD_BUSY;
                  md_busy <= 1'b1;
                  cnt     <= md_is_div_EX ? CW'(DIV_CYCLES - 2) : CW'(MULT_CYCLES - 2);
               end
            end
            MD_BUSY: begin
               if (!md_start_EX) begin
                  state   <= MD_IDLE;
                  md_busy <= 1'b0;
               end else if (cnt == '0) begin
                  state   <= MD_DONE;
                  md_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            MD_DONE: begin
               if (en_ex)
                  state <= MD_IDLE;
            end
            default: begin
               state   <= MD_IDLE;
               md_busy <= 1'b0;
            end
         endcase
      end
   end

   assign md_hold = md_start_EX & (state != MD_DONE);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - merges dmem wait, mult/div occupancy and hazard stalls into stage enables/flushes
module pipeline_stall_ctrl #(
   parameter int MULT_CYCLES = mips_ctrl_pkg::MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = mips_ctrl_pkg::DIV_CYCLES_DEF,
   parameter int MEM_TIMEOUT = mips_ctrl_pkg::MEM_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall_ID_HU,
   input  logic        PCSrc_ID,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic        dmem_ready,
   input  logic        md_start_EX,
   input  logic        md_is_div_EX,
   output logic        En_IF,
   output logic        En_ID,
   output logic        En_EX,
   output logic        En_MEM,
   output logic        Flush_ID,
   output logic        Flush_EX,
   output logic        Flush_MEM,
   output logic        Flush_WB,
   output logic        dmem_req,
   output logic        md_busy,
   output logic        mem_err,
   output logic [31:0] stall_cycles
);
   import mips_ctrl_pkg::*;

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   mem_state_t       mstate;
   logic [WCW-1:0]   wcnt;
   logic             acc;
   logic             mem_hold;
   logic             md_hold;
   logic             en_ex_raw;
   logic             en_if_raw;

   assign acc      = MemRead_MEM | MemWrite_MEM;
   assign mem_hold = (acc & ~dmem_ready) | (mstate == M_ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mstate  <= M_RUN;
         wcnt    <= '0;
         mem_err <= 1'b0;
      end else begin
         case (mstate)
            M_RUN: begin
               if (acc & ~dmem_ready) begin
                  mstate <= M_WAIT;
                  wcnt   <= WCW'(1);
               end
            end
            M_WAIT: begin
               if (dmem_ready) begin
                  mstate <= M_RUN;
               end else if (wcnt + 1'b1 == WCW'(MEM_TIMEOUT)) begin
                  mstate  <= M_ERR;
                  mem_err <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            M_ERR: mstate <= M_ERR;
            default: mstate <= M_RUN;
         endcase
      end
   end

   md_occupancy_ctr #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md (
      .clk          (clk),
      .reset        (reset),
      .md_start_EX  (md_start_EX),
      .md_is_div_EX (md_is_div_EX),
      .en_ex        (en_ex_raw),
      .md_hold      (md_hold),
      .md_busy      (md_busy)
   );

   assign en_ex_raw = ~mem_hold & ~md_hold;
   assign en_if_raw = en_ex_raw & ~Stall_ID_HU;

   // Reset is folded in combinationally so enables drop and bubbles load the moment reset rises.
   assign En_MEM    = ~reset & ~mem_hold;
   assign En_EX     = ~reset & en_ex_raw;
   assign En_IF     = ~reset & en_if_raw;
   assign En_ID     = ~reset & en_if_raw;
   assign Flush_WB  = reset | mem_hold;
   assign Flush_MEM = reset | (md_hold & ~mem_hold);
   assign Flush_EX  = reset | (en_ex_raw & Stall_ID_HU);
   assign Flush_ID  = reset | (en_if_raw & PCSrc_ID);
   assign dmem_req  = ~reset & acc & (mstate != M_ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles <= '0;
      else if (!en_if_raw && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed vector table plus multi-cycle sequences for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall_ID_HU, PCSrc_ID, MemRead_MEM, MemWrite_MEM, dmem_ready;
   logic        md_start_EX, md_is_div_EX;
   logic        En_IF, En_ID, En_EX, En_MEM;
   logic        Flush_ID, Flush_EX, Flush_MEM, Flush_WB;
   logic        dmem_req, md_busy, mem_err;
   logic [31:0] stall_cycles;

   int tests = 0;
   int fails = 0;

   // {En_IF,En_ID,En_EX,En_MEM, Flush_ID,Flush_EX,Flush_MEM,Flush_WB, dmem_req}
   logic [8:0] outs;
   assign outs = {En_IF, En_ID, En_EX, En_MEM, Flush_ID, Flush_EX, Flush_MEM, Flush_WB, dmem_req};

   localparam logic [8:0] O_RUN   = 9'b1111_0000_0;
   localparam logic [8:0] O_RST   = 9'b0000_1111_0;
   localparam logic [8:0] O_MHOLD = 9'b0000_0001_1;
   localparam logic [8:0] O_ERR   = 9'b0000_0001_0;

   // in = {stall, pcsrc, memread, memwrite, ready, md_start, md_is_div}
   typedef struct packed {
      logic [6:0] in;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs [11];

   pipeline_stall_ctrl #(
      .MULT_CYCLES (4),
      .DIV_CYCLES  (32),
      .MEM_TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Stall_ID_HU  (Stall_ID_HU),
      .PCSrc_ID     (PCSrc_ID),
      .MemRead_MEM  (MemRead_MEM),
      .MemWrite_MEM (MemWrite_MEM),
      .dmem_ready   (dmem_ready),
      .md_start_EX  (md_start_EX),
      .md_is_div_EX (md_is_div_EX),
      .En_IF        (En_IF),
      .En_ID        (En_ID),
      .En_EX        (En_EX),
      .En_MEM       (En_MEM),
      .Flush_ID     (Flush_ID),
      .Flush_EX     (Flush_EX),
      .Flush_MEM    (Flush_MEM),
      .Flush_WB     (Flush_WB),
      .dmem_req     (dmem_req),
      .md_busy      (md_busy),
      .mem_err      (mem_err),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [6:0] v);
      {Stall_ID_HU, PCSrc_ID, MemRead_MEM, MemWrite_MEM, dmem_ready, md_start_EX, md_is_div_EX} = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      set_in(7'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic md_run(input logic is_div, input int n, input string nm);
      int held, fm, busy;
      bit done;
      held = 0; fm = 0; busy = 0; done = 0;
      do_reset();
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         md_start_EX  = 1'b1;
         md_is_div_EX = is_div;
         #1;
         if (En_EX === 1'b1) begin
            done = 1;
         end else begin
            held++;
            if (Flush_MEM === 1'b1) fm++;
            if (md_busy === 1'b1) busy++;
         end
      end
      check({nm, "_done"}, 32'(done), 32'd1);
      check({nm, "_hold_cycles"}, held, n);
      check({nm, "_flush_mem_cycles"}, fm, n);
      check({nm, "_busy_cycles"}, busy, n - 1);
      check({nm, "_exit_outs"}, 32'(outs), 32'(O_RUN));
      @(negedge clk);
      md_start_EX  = 1'b0;
      md_is_div_EX = 1'b0;
      #1;
      check({nm, "_after_outs"}, 32'(outs), 32'(O_RUN));
      check({nm, "_after_busy"}, 32'(md_busy), 32'd0);
      check({nm, "_stall_cycles"}, stall_cycles, n);
   endtask

   initial begin
      int n;
      bit seen;

      vecs[0]  = '{in: 7'b0000000, exp: 9'b1111_0000_0};
      vecs[1]  = '{in: 7'b0100000, exp: 9'b1111_1000_0};
      vecs[2]  = '{in: 7'b1000000, exp: 9'b0011_0100_0};
      vecs[3]  = '{in: 7'b1100000, exp: 9'b0011_0100_0};
      vecs[4]  = '{in: 7'b0010100, exp: 9'b1111_0000_1};
      vecs[5]  = '{in: 7'b0010000, exp: 9'b0000_0001_1};
      vecs[6]  = '{in: 7'b1101000, exp: 9'b0000_0001_1};
      vecs[7]  = '{in: 7'b0000010, exp: 9'b0001_0010_0};
      vecs[8]  = '{in: 7'b0010010, exp: 9'b0000_0001_1};
      vecs[9]  = '{in: 7'b0101111, exp: 9'b0001_0010_1};
      vecs[10] = '{in: 7'b0000100, exp: 9'b1111_0000_0};

      reset = 1'b1;
      set_in(7'b0);
      #2;
      check("reset_outs", 32'(outs), 32'(O_RST));
      check("reset_md_busy", 32'(md_busy), 32'd0);
      check("reset_mem_err", 32'(mem_err), 32'd0);
      check("reset_stall_cycles", stall_cycles, 32'd0);

      // Each vector starts from clean FSM state and is observed between clock edges.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         reset = 1'b1;
         set_in(vecs[i].in);
         #1 reset = 1'b0;
         #1 check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
         #1 reset = 1'b1;
      end

      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1 check($sformatf("idle_c%0d", i), 32'(outs), 32'(O_RUN));
      end
      check("idle_stall_cycles", stall_cycles, 32'd0);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         MemRead_MEM = 1'b1; dmem_ready = 1'b0;
         #1 check($sformatf("load3_wait%0d", i), 32'(outs), 32'(O_MHOLD));
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1 check("load3_ready", 32'(outs), 32'(9'b1111_0000_1));
      @(negedge clk);
      MemRead_MEM = 1'b0; dmem_ready = 1'b0;
      #1 check("load3_after", 32'(outs), 32'(O_RUN));
      check("load3_stall_cycles", stall_cycles, 32'd3);

      @(negedge clk);
      MemRead_MEM = 1'b1; dmem_ready = 1'b1;
      #1 check("load0_pass", 32'(outs), 32'(9'b1111_0000_1));
      @(negedge clk);
      MemRead_MEM = 1'b0; dmem_ready = 1'b0;
      #1 check("load0_after", 32'(outs), 32'(O_RUN));
      check("load0_stall_cycles", stall_cycles, 32'd3);

      md_run(1'b0, 4, "mult");
      md_run(1'b1, 32, "div");

      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         MemRead_MEM = 1'b1; dmem_ready = 1'b0; md_start_EX = 1'b1;
         #1 check($sformatf("mdmem_wait%0d", i), 32'(outs), 32'(O_MHOLD));
         if (i == 2) check("mdmem_busy_mid", 32'(md_busy), 32'd1);
      end
      check("mdmem_done_busy", 32'(md_busy), 32'd0);
      @(negedge clk);
      dmem_ready = 1'b1;
      #1 check("mdmem_ready", 32'(outs), 32'(9'b1111_0000_1));
      @(negedge clk);
      set_in(7'b0);
      #1 check("mdmem_after", 32'(outs), 32'(O_RUN));
      check("mdmem_stall_cycles", stall_cycles, 32'd6);

      do_reset();
      @(negedge clk);
      Stall_ID_HU = 1'b1; PCSrc_ID = 1'b1;
      #1 check("haz_stall_branch", 32'(outs), 32'(9'b0011_0100_0));
      @(negedge clk);
      Stall_ID_HU = 1'b0;
      #1 check("haz_branch_flush", 32'(outs), 32'(9'b1111_1000_0));
      @(negedge clk);
      PCSrc_ID = 1'b0;

      do_reset();
      n = 0; seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         MemRead_MEM = 1'b1; dmem_ready = 1'b0;
         #1;
         if (mem_err === 1'b1) seen = 1;
         else n++;
      end
      check("tmo_seen", 32'(seen), 32'd1);
      check("tmo_wait_cycles", n, 8);
      check("tmo_err_outs", 32'(outs), 32'(O_ERR));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         MemRead_MEM = 1'b0;
         #1 check($sformatf("tmo_idle%0d", i), 32'(outs), 32'(O_ERR));
      end
      @(negedge clk);
      MemRead_MEM = 1'b1; dmem_ready = 1'b1;
      #1 check("tmo_ready_ignored", 32'(outs), 32'(O_ERR));
      check("tmo_err_sticky", 32'(mem_err), 32'd1);

      @(posedge clk);
      #3 reset = 1'b1;
      #1 check("async_rst_outs", 32'(outs), 32'(O_RST));
      check("async_rst_mem_err", 32'(mem_err), 32'd0);
      check("async_rst_stall", stall_cycles, 32'd0);
      set_in(7'b0);
      #1 reset = 1'b0;
      #1 check("async_rel_outs", 32'(outs), 32'(O_RUN));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
